// File: rtl/spi_master_if.sv
// Controller-side byte handshake plus the board-level SPI pins of spi_master.
interface spi_master_if;
  logic [7:0] Tx_Byte;
  logic       Tx_Hold;
  logic       Tx_DV;
  logic       Tx_Ready;
  logic [7:0] Rx_Byte;
  logic       Rx_DV;
  logic       SPI_Clk;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       SPI_CS;

  modport master (
    input  Tx_Byte, Tx_Hold, Tx_DV, SPI_MISO,
    output Tx_Ready, Rx_Byte, Rx_DV, SPI_Clk, SPI_MOSI, SPI_CS
  );

  modport slave (
    output Tx_Byte, Tx_Hold, Tx_DV, SPI_MISO,
    input  Tx_Ready, Rx_Byte, Rx_DV, SPI_Clk, SPI_MOSI, SPI_CS
  );
endinterface

// File: rtl/spi_master.sv
// Mode 0 SPI master: one byte per Tx_DV, MSB first, CS held low across
// bytes flagged with Tx_Hold. Every output comes straight from a register.
module spi_master #(
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int CS_IDLE_CYCLES    = 8
) (
  input  logic          clk,
  input  logic          resetn,
  spi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, TAIL, GAP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_IDLE_CYCLES - 1);

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt;         // half-period / tail / gap counter
  logic [2:0] r_bit, w_bit;         // falling edges seen in this byte
  logic       r_fin, w_fin;         // 8th falling edge just happened
  logic       r_sclk, w_sclk;       // also the edge-phase flag
  logic       r_mosi, w_mosi;
  logic       r_cs, w_cs;
  logic [6:0] r_tx, w_tx;           // bits still to send after the current one
  logic [7:0] r_rx, w_rx;
  logic       r_hold, w_hold;
  logic [7:0] r_rx_byte, w_rx_byte;
  logic       r_rx_dv, w_rx_dv;
  logic       r_ready, w_ready;
  logic       w_wrap;

  assign w_wrap = (r_cnt == HALF_LAST);

  // Next-state and next-output computation for every register.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_bit     = r_bit;
    w_fin     = 1'b0;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;
    w_cs      = r_cs;
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_hold    = r_hold;
    w_rx_byte = r_rx_byte;
    w_rx_dv   = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        if (bus.Tx_DV) begin
          w_tx    = bus.Tx_Byte[6:0];
          w_mosi  = bus.Tx_Byte[7];
          w_hold  = bus.Tx_Hold;
          w_cs    = 1'b0;
          w_cnt   = 8'd0;
          w_bit   = 3'd0;
          w_state = SETUP;
        end
      end
      SETUP: begin
        if (w_wrap) begin
          w_cnt   = 8'd0;
          w_sclk  = 1'b1;
          w_state = XFER;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      XFER: begin
        // Counter keeps running through the finish cycle so TAIL lands
        // exactly one half period after the last falling edge.
        w_cnt = w_wrap ? 8'd0 : r_cnt + 8'd1;
        if (r_fin) begin
          w_rx_byte = r_rx;
          w_rx_dv   = 1'b1;
          w_state   = r_hold ? HOLD : TAIL;
        end else if (w_wrap) begin
          w_sclk = ~r_sclk;
          if (r_sclk) begin
            // Sample MISO as late as possible in the high phase.
            w_rx  = {r_rx[6:0], bus.SPI_MISO};
            w_bit = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              w_fin = 1'b1;
            end else begin
              w_mosi = r_tx[6];
              w_tx   = {r_tx[5:0], 1'b0};
            end
          end
        end
      end
      TAIL: begin
        if (w_wrap) begin
          w_cs    = 1'b1;
          w_cnt   = 8'd0;
          w_state = GAP;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt   = 8'd0;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: w_state = IDLE;
    endcase
    w_ready = (w_state == IDLE) || (w_state == HOLD);
  end

  // State and output registers; reset drops any partial byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_bit     <= 3'd0;
      r_fin     <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= 1'b1;
      r_tx      <= 7'd0;
      r_rx      <= 8'd0;
      r_hold    <= 1'b0;
      r_rx_byte <= 8'd0;
      r_rx_dv   <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bit     <= w_bit;
      r_fin     <= w_fin;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
      r_cs      <= w_cs;
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_hold    <= w_hold;
      r_rx_byte <= w_rx_byte;
      r_rx_dv   <= w_rx_dv;
      r_ready   <= w_ready;
    end
  end

  assign bus.SPI_Clk  = r_sclk;
  assign bus.SPI_MOSI = r_mosi;
  assign bus.SPI_CS   = r_cs;
  assign bus.Rx_Byte  = r_rx_byte;
  assign bus.Rx_DV    = r_rx_dv;
  assign bus.Tx_Ready = r_ready;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default instance plus a fast (H=2, gap=1) instance.
module tb_spi_master;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  spi_master_if bus ();
  spi_master_if bus2 ();

  spi_master #(.CLKS_PER_HALF_BIT(4), .CS_IDLE_CYCLES(8)) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus));
  spi_master #(.CLKS_PER_HALF_BIT(2), .CS_IDLE_CYCLES(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2));

  // Mode 0 slave: presents bit 7 when CS falls, shifts on SCLK falling edges.
  logic       loop_en = 1'b1;
  logic [7:0] sl_byte = 8'h00;
  logic [7:0] sl_sh   = 8'h00;
  assign bus.SPI_MISO  = loop_en ? bus.SPI_MOSI : sl_sh[7];
  assign bus2.SPI_MISO = bus2.SPI_MOSI;

  always @(negedge bus.SPI_CS) sl_sh <= sl_byte;
  always @(negedge bus.SPI_Clk) if (bus.SPI_CS == 1'b0) sl_sh <= {sl_sh[6:0], 1'b0};

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];

  // One clock; scoreboard pops/compares whenever either DUT reports a byte.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (bus.Rx_DV === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL sb_rx: got %h, expected no byte", bus.Rx_Byte);
      end else begin
        e = exp_q.pop_front();
        if (bus.Rx_Byte !== e) begin
          n_err++; $display("FAIL sb_rx: got %h, expected %h", bus.Rx_Byte, e);
        end
      end
    end
    if (bus2.Rx_DV === 1'b1) begin
      n_cmp++;
      if (exp_q2.size() == 0) begin
        n_err++; $display("FAIL sb_rx2: got %h, expected no byte", bus2.Rx_Byte);
      end else begin
        e = exp_q2.pop_front();
        if (bus2.Rx_Byte !== e) begin
          n_err++; $display("FAIL sb_rx2: got %h, expected %h", bus2.Rx_Byte, e);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic hold);
    bus.Tx_Byte = b; bus.Tx_Hold = hold; bus.Tx_DV = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if ({bus.SPI_CS, bus.SPI_Clk, bus.SPI_MOSI, bus.Tx_Ready, bus.Rx_DV, bus.Rx_Byte} !== 13'b1_0_0_1_0_00000000) begin
      n_err++; $display("FAIL reset_state: got cs%b clk%b mosi%b rdy%b dv%b rx%h, expected cs1 clk0 mosi0 rdy1 dv0 rx00",
        bus.SPI_CS, bus.SPI_Clk, bus.SPI_MOSI, bus.Tx_Ready, bus.Rx_DV, bus.Rx_Byte);
    end
    n_cmp++;
    if ({bus2.SPI_CS, bus2.SPI_Clk, bus2.Tx_Ready} !== 3'b101) begin
      n_err++; $display("FAIL reset_state2: got cs%b clk%b rdy%b, expected cs1 clk0 rdy1",
        bus2.SPI_CS, bus2.SPI_Clk, bus2.Tx_Ready);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_loopback();
    int cs_low = 0, nrise = 0, dv_n = 0, dv_k = -1, rdy_k = -1, last_r = -1, per_bad = 0;
    logic [7:0] bits = 8'h00;
    logic prev = 1'b0;
    loop_en = 1'b1;
    send(8'hA5, 1'b0); exp_q.push_back(8'hA5);
    for (int k = 1; k <= 90; k++) begin
      tick();
      bus.Tx_DV = 1'b0;
      if (k == 1) begin
        n_cmp++;
        if ({bus.SPI_CS, bus.SPI_MOSI, bus.Tx_Ready} !== 3'b010) begin
          n_err++; $display("FAIL first_cycle: got cs%b mosi%b rdy%b, expected cs0 mosi1 rdy0",
            bus.SPI_CS, bus.SPI_MOSI, bus.Tx_Ready);
        end
      end
      if (bus.SPI_CS == 1'b0) cs_low++;
      if (bus.SPI_Clk && !prev) begin
        nrise++; bits = {bits[6:0], bus.SPI_MOSI};
        if (last_r >= 0 && k - last_r != 8) per_bad++;
        last_r = k;
      end
      prev = bus.SPI_Clk;
      if (bus.Rx_DV) begin dv_n++; dv_k = k; end
      if (bus.Tx_Ready && rdy_k < 0) rdy_k = k;
    end
    n_cmp++; if (bits !== 8'hA5) begin n_err++; $display("FAIL a5_mosi_bits: got %h, expected a5", bits); end
    n_cmp++; if (dv_n != 1 || dv_k != 66) begin n_err++; $display("FAIL a5_rxdv: got %0d pulses last at %0d, expected 1 at 66", dv_n, dv_k); end
    n_cmp++; if (cs_low != 68) begin n_err++; $display("FAIL a5_cs_low: got %0d, expected 68", cs_low); end
    n_cmp++; if (rdy_k != 77) begin n_err++; $display("FAIL a5_ready: got %0d, expected 77", rdy_k); end
    n_cmp++; if (nrise != 8 || per_bad != 0) begin n_err++; $display("FAIL a5_sclk: got %0d rises %0d bad periods, expected 8 and 0", nrise, per_bad); end
  endtask

  task automatic test_slave_3c();
    int nrise = 0, last_r = -1, per_bad = 0, mosi_bad = 0;
    logic prev = 1'b0;
    loop_en = 1'b0; sl_byte = 8'h3C;
    send(8'hFF, 1'b0); exp_q.push_back(8'h3C);
    for (int k = 1; k <= 90; k++) begin
      tick();
      bus.Tx_DV = 1'b0;
      if (bus.SPI_CS == 1'b0 && bus.SPI_MOSI !== 1'b1) mosi_bad++;
      if (bus.SPI_Clk && !prev) begin
        nrise++;
        if (last_r >= 0 && k - last_r != 8) per_bad++;
        last_r = k;
      end
      prev = bus.SPI_Clk;
    end
    n_cmp++; if (mosi_bad != 0) begin n_err++; $display("FAIL ff_mosi: got %0d cycles not 1, expected 0", mosi_bad); end
    n_cmp++; if (nrise != 8) begin n_err++; $display("FAIL ff_rises: got %0d, expected 8", nrise); end
    n_cmp++; if (per_bad != 0) begin n_err++; $display("FAIL ff_period: got %0d bad periods, expected 0", per_bad); end
    loop_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int dv_n = 0, cs_bad = 0, gap_bad = 0, rdy_k = -1, rise_k = -1;
    send(8'h12, 1'b1); exp_q.push_back(8'h12);
    for (int k = 1; k <= 150; k++) begin
      tick();
      bus.Tx_DV = 1'b0;
      if (bus.Rx_DV) dv_n++;
      if (bus.SPI_CS != 1'b0) cs_bad++;
      if (bus.Tx_Ready && k > 1) begin rdy_k = k; break; end
    end
    n_cmp++; if (rdy_k != 66) begin n_err++; $display("FAIL hold_ready: got %0d, expected 66", rdy_k); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.SPI_CS != 1'b0 || bus.SPI_Clk != 1'b0 || bus.Tx_Ready != 1'b1) gap_bad++;
    end
    send(8'h34, 1'b0); exp_q.push_back(8'h34);
    for (int k = 1; k <= 120; k++) begin
      tick();
      bus.Tx_DV = 1'b0;
      if (bus.Rx_DV) dv_n++;
      if (bus.SPI_CS == 1'b1 && rise_k < 0) rise_k = k;
    end
    n_cmp++; if (cs_bad != 0) begin n_err++; $display("FAIL b2b_cs: got %0d high cycles, expected 0", cs_bad); end
    n_cmp++; if (gap_bad != 0) begin n_err++; $display("FAIL b2b_gap: got %0d bad cycles, expected 0", gap_bad); end
    n_cmp++; if (dv_n != 2) begin n_err++; $display("FAIL b2b_rxdv: got %0d, expected 2", dv_n); end
    n_cmp++; if (rise_k != 69) begin n_err++; $display("FAIL b2b_cs_rise: got %0d, expected 69", rise_k); end
  endtask

  task automatic test_ignored();
    int cs_low = 0, dv_n = 0, falls = 0;
    logic prev_cs = 1'b1;
    send(8'hA5, 1'b0); exp_q.push_back(8'hA5);
    for (int k = 1; k <= 100; k++) begin
      tick();
      bus.Tx_DV = 1'b0;
      if (k == 10) begin bus.Tx_Byte = 8'h55; bus.Tx_DV = 1'b1; end
      if (bus.SPI_CS == 1'b0) cs_low++;
      if (prev_cs && !bus.SPI_CS) falls++;
      prev_cs = bus.SPI_CS;
      if (bus.Rx_DV) dv_n++;
    end
    n_cmp++; if (cs_low != 68 || falls != 1) begin n_err++; $display("FAIL ign_cs: got %0d low %0d falls, expected 68 and 1", cs_low, falls); end
    n_cmp++; if (dv_n != 1 || bus.Rx_Byte !== 8'hA5) begin n_err++; $display("FAIL ign_rx: got %0d pulses rx %h, expected 1 and a5", dv_n, bus.Rx_Byte); end
  endtask

  task automatic test_reset_mid();
    int dv_n = 0;
    send(8'hA5, 1'b0);
    for (int k = 1; k <= 29; k++) begin tick(); bus.Tx_DV = 1'b0; end
    n_cmp++; if (bus.SPI_CS !== 1'b0) begin n_err++; $display("FAIL rst_pre_cs: got %b, expected 0", bus.SPI_CS); end
    tick();
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.SPI_CS, bus.SPI_Clk, bus.SPI_MOSI, bus.Tx_Ready, bus.Rx_DV} !== 5'b10010) begin
      n_err++; $display("FAIL rst_mid: got cs%b clk%b mosi%b rdy%b dv%b, expected cs1 clk0 mosi0 rdy1 dv0",
        bus.SPI_CS, bus.SPI_Clk, bus.SPI_MOSI, bus.Tx_Ready, bus.Rx_DV);
    end
    for (int k = 0; k < 3; k++) tick();
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(); if (bus.Rx_DV) dv_n++; end
    send(8'h0F, 1'b0); exp_q.push_back(8'h0F);
    for (int k = 1; k <= 90; k++) begin tick(); bus.Tx_DV = 1'b0; if (bus.Rx_DV) dv_n++; end
    n_cmp++; if (dv_n != 1 || bus.Rx_Byte !== 8'h0F) begin n_err++; $display("FAIL rst_after: got %0d pulses rx %h, expected 1 and 0f", dv_n, bus.Rx_Byte); end
  endtask

  task automatic test_param();
    int nrise = 0, last_r = -1, per_bad = 0, dv_n = 0, rdy_k = -1;
    logic [7:0] bits = 8'h00;
    logic prev = 1'b0;
    bus2.Tx_Byte = 8'hC3; bus2.Tx_Hold = 1'b0; bus2.Tx_DV = 1'b1; exp_q2.push_back(8'hC3);
    for (int k = 1; k <= 50; k++) begin
      tick();
      bus2.Tx_DV = 1'b0;
      if (bus2.SPI_Clk && !prev) begin
        nrise++; bits = {bits[6:0], bus2.SPI_MOSI};
        if (last_r >= 0 && k - last_r != 4) per_bad++;
        last_r = k;
      end
      prev = bus2.SPI_Clk;
      if (bus2.Rx_DV) dv_n++;
      if (bus2.Tx_Ready && rdy_k < 0) rdy_k = k;
    end
    n_cmp++; if (nrise != 8 || per_bad != 0) begin n_err++; $display("FAIL p_sclk: got %0d rises %0d bad periods, expected 8 and 0", nrise, per_bad); end
    n_cmp++; if (bits !== 8'hC3 || dv_n != 1) begin n_err++; $display("FAIL p_data: got bits %h %0d pulses, expected c3 and 1", bits, dv_n); end
    n_cmp++; if (rdy_k != 36) begin n_err++; $display("FAIL p_ready: got %0d, expected 36", rdy_k); end
  endtask

  initial begin
    bus.Tx_Byte = 8'h00;  bus.Tx_Hold = 1'b0;  bus.Tx_DV = 1'b0;
    bus2.Tx_Byte = 8'h00; bus2.Tx_Hold = 1'b0; bus2.Tx_DV = 1'b0;
    test_reset();
    test_loopback();
    test_slave_3c();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_param();
    n_cmp++;
    if (exp_q.size() != 0 || exp_q2.size() != 0) begin
      n_err++; $display("FAIL sb_left: got %0d/%0d bytes outstanding, expected 0/0", exp_q.size(), exp_q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
